// File: rtl/pacote_nrisc.sv
// nRISC multi-cycle control: shared states, opcodes, ALU codes and IR fields.
// Imported by the decoder, the control FSM and the bench.
package pacote_nrisc;

  typedef enum logic [2:0] {
    ST_BUSCA      = 3'd0,
    ST_DECODIFICA = 3'd1,
    ST_EXECUTA    = 3'd2,
    ST_MEMORIA    = 3'd3,
    ST_ESCRITA    = 3'd4,
    ST_BUSCA_OP2  = 3'd5,
    ST_PARADO     = 3'd6
  } estado_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BEQZ = 4'hA;
  localparam logic [3:0] OP_NOP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;

  localparam int IR_OP_MSB = 7;
  localparam int IR_OP_LSB = 4;
  localparam int IR_RA_MSB = 3;
  localparam int IR_RA_LSB = 2;
  localparam int IR_RB_MSB = 1;
  localparam int IR_RB_LSB = 0;

  typedef struct packed {
    logic alu;
    logic imm;
    logic lw;
    logic sw;
    logic jmp;
    logic beqz;
    logic nop;
    logic halt;
  } classe_t;

endpackage

// File: rtl/decodificador_instrucao.sv
// nRISC opcode -> one-hot instruction class plus ALU operation.
// Opcodes C-E fall into the halt class.
module decodificador_instrucao
  import pacote_nrisc::*;
(
  input  logic [3:0] i_opcode,
  output classe_t    o_classe,
  output logic [2:0] o_alu_op
);

  always_comb begin
    o_classe = '0;
    o_alu_op = ALU_ADD;
    unique case (1'b1)
      (i_opcode <= OP_NOT): begin
        o_classe.alu = 1'b1;
        o_alu_op     = i_opcode[2:0];
      end
      (i_opcode == OP_ADDI): o_classe.imm  = 1'b1;
      (i_opcode == OP_LW):   o_classe.lw   = 1'b1;
      (i_opcode == OP_SW):   o_classe.sw   = 1'b1;
      (i_opcode == OP_JMP):  o_classe.jmp  = 1'b1;
      (i_opcode == OP_BEQZ): o_classe.beqz = 1'b1;
      (i_opcode == OP_NOP):  o_classe.nop  = 1'b1;
      default:               o_classe.halt = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// nRISC multi-cycle control FSM: fetch, decode, execute, memory, write-back.
// Define MEM_TIMEOUT_EN to halt with erro_mem on a stuck mem_pronto.
module unidade_controle_multiciclo
  import pacote_nrisc::*;
#(
  parameter int LARGURA_PC  = 8,
  parameter int TIMEOUT_MEM = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            mem_dado,
  input  logic                  mem_pronto,
  input  logic                  zero,
  output logic [LARGURA_PC-1:0] pc,
  output logic                  sel_end_mem,
  output logic                  mem_le,
  output logic                  mem_escreve,
  output logic                  carrega_mdr,
  output logic [1:0]            end_leitura_A,
  output logic [1:0]            end_leitura_B,
  output logic [1:0]            end_escrita,
  output logic                  habilita_escrita,
  output logic                  sel_dado_escrita,
  output logic [2:0]            alu_op,
  output logic                  alu_src_imm,
  output logic [7:0]            imediato,
  output logic                  parado,
  output logic                  erro_mem
);

  if (TIMEOUT_MEM < 1) begin : g_cfg_invalida
    $error("TIMEOUT_MEM must be at least 1");
  end

  estado_t               r_estado;
  estado_t               w_prox;
  logic [7:0]            r_ir;
  logic [LARGURA_PC-1:0] r_pc;
  logic                  r_flag_desvio;
  classe_t               w_classe;
  logic [2:0]            w_alu_op;
  logic                  w_espera;
  logic                  w_timeout;
  logic                  w_desvia;

  decodificador_instrucao u_dec (
    .i_opcode (r_ir[IR_OP_MSB:IR_OP_LSB]),
    .o_classe (w_classe),
    .o_alu_op (w_alu_op)
  );

  assign w_espera = (r_estado == ST_BUSCA) ||
                    (r_estado == ST_BUSCA_OP2) ||
                    (r_estado == ST_MEMORIA);
  assign w_desvia = w_classe.jmp ||
                    (w_classe.beqz && r_flag_desvio);
  assign pc = r_pc;

`ifdef MEM_TIMEOUT_EN
  localparam int LARG_CNT = $clog2(TIMEOUT_MEM + 1);

  logic [LARG_CNT-1:0] r_cnt;
  logic                r_erro;

  assign w_timeout = w_espera && !mem_pronto &&
                     (r_cnt == LARG_CNT'(TIMEOUT_MEM));
  assign erro_mem  = r_erro;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_erro <= 1'b0;
    end else begin
      if (r_estado != w_prox)
        r_cnt <= '0;
      else if (w_espera)
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_erro <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign erro_mem  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado      <= ST_BUSCA;
      r_ir          <= '0;
      r_pc          <= '0;
      r_flag_desvio <= 1'b0;
    end else begin
      r_estado <= w_prox;
      if (r_estado == ST_BUSCA && mem_pronto) begin
        r_ir <= mem_dado;
        r_pc <= r_pc + 1'b1;
      end
      if (r_estado == ST_EXECUTA && w_classe.beqz)
        r_flag_desvio <= zero;
      if (r_estado == ST_BUSCA_OP2 && mem_pronto)
        r_pc <= w_desvia ? LARGURA_PC'(mem_dado)
                         : r_pc + 1'b1;
    end
  end

  always_comb begin
    w_prox           = r_estado;
    sel_end_mem      = 1'b0;
    mem_le           = 1'b0;
    mem_escreve      = 1'b0;
    carrega_mdr      = 1'b0;
    end_leitura_A    = 2'd0;
    end_leitura_B    = 2'd0;
    end_escrita      = 2'd0;
    habilita_escrita = 1'b0;
    sel_dado_escrita = 1'b0;
    alu_op           = ALU_ADD;
    alu_src_imm      = 1'b0;
    imediato         = 8'd0;
    parado           = 1'b0;

    unique case (r_estado)
      ST_BUSCA: begin
        // reset sits in BUSCA, so the strobe is gated to stay quiet in reset
        mem_le = ~reset;
        if (mem_pronto)
          w_prox = ST_DECODIFICA;
        else if (w_timeout)
          w_prox = ST_PARADO;
      end
      ST_DECODIFICA: begin
        unique case (1'b1)
          w_classe.jmp:  w_prox = ST_BUSCA_OP2;
          w_classe.nop:  w_prox = ST_BUSCA;
          w_classe.halt: w_prox = ST_PARADO;
          default:       w_prox = ST_EXECUTA;
        endcase
      end
      ST_EXECUTA: begin
        if (w_classe.beqz)
          w_prox = ST_BUSCA_OP2;
        else if (w_classe.lw || w_classe.sw)
          w_prox = ST_MEMORIA;
        else
          w_prox = ST_ESCRITA;
      end
      ST_MEMORIA: begin
        sel_end_mem = 1'b1;
        mem_le      = w_classe.lw;
        mem_escreve = w_classe.sw;
        if (mem_pronto) begin
          carrega_mdr = w_classe.lw;
          w_prox = w_classe.lw ? ST_ESCRITA : ST_BUSCA;
        end else if (w_timeout) begin
          w_prox = ST_PARADO;
        end
      end
      ST_ESCRITA: begin
        habilita_escrita = 1'b1;
        sel_dado_escrita = w_classe.lw;
        w_prox           = ST_BUSCA;
      end
      ST_BUSCA_OP2: begin
        mem_le = 1'b1;
        if (mem_pronto)
          w_prox = ST_BUSCA;
        else if (w_timeout)
          w_prox = ST_PARADO;
      end
      ST_PARADO: parado = 1'b1;
      default:   w_prox = ST_BUSCA;
    endcase

    if (r_estado != ST_BUSCA) begin
      end_leitura_A = r_ir[IR_RA_MSB:IR_RA_LSB];
      end_leitura_B = r_ir[IR_RB_MSB:IR_RB_LSB];
      end_escrita   = r_ir[IR_RA_MSB:IR_RA_LSB];
    end

    // ALU controls held into ESCRITA so the result stays stable while written
    if (r_estado == ST_EXECUTA || r_estado == ST_ESCRITA) begin
      alu_op      = w_alu_op;
      alu_src_imm = w_classe.imm || w_classe.beqz;
      imediato    = w_classe.beqz ? 8'd0
                    : {6'd0, r_ir[IR_RB_MSB:IR_RB_LSB]};
    end
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo.
// Table of single instructions plus multi-cycle corner sequences.
module tb_unidade_controle_multiciclo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem_dado;
  logic       mem_pronto = 1'b1;
  logic       zero = 1'b0;
  logic [7:0] pc;
  logic       sel_end_mem, mem_le, mem_escreve, carrega_mdr;
  logic [1:0] end_leitura_A, end_leitura_B, end_escrita;
  logic       habilita_escrita, sel_dado_escrita;
  logic [2:0] alu_op;
  logic       alu_src_imm;
  logic [7:0] imediato;
  logic       parado, erro_mem;

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_dado = sel_end_mem ? 8'h5A : mem[pc];

  unidade_controle_multiciclo #(
    .LARGURA_PC (8),
    .TIMEOUT_MEM(15)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_dado        (mem_dado),
    .mem_pronto      (mem_pronto),
    .zero            (zero),
    .pc              (pc),
    .sel_end_mem     (sel_end_mem),
    .mem_le          (mem_le),
    .mem_escreve     (mem_escreve),
    .carrega_mdr     (carrega_mdr),
    .end_leitura_A   (end_leitura_A),
    .end_leitura_B   (end_leitura_B),
    .end_escrita     (end_escrita),
    .habilita_escrita(habilita_escrita),
    .sel_dado_escrita(sel_dado_escrita),
    .alu_op          (alu_op),
    .alu_src_imm     (alu_src_imm),
    .imediato        (imediato),
    .parado          (parado),
    .erro_mem        (erro_mem)
  );

  typedef struct {
    logic [7:0] instr;
    logic [7:0] byte2;
    logic       zero;
    int         lat;
    logic [7:0] pc_fim;
    logic       halt;
    int         n_le;
    int         n_esc;
    int         we_ciclo;
    logic       sel_dado;
    logic       chk_exec;
    logic [2:0] alu_op;
    logic       src_imm;
    logic [7:0] imed;
  } vec_t;

  vec_t tab[17];

  task automatic chk(input string nome, input logic [31:0] atual,
                     input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int le_n, esc_n, we_n, we_at;
    logic conflito;
    logic [1:0] ee, la, lb;
    logic sd, src;
    logic [2:0] op;
    logic [7:0] im;
    le_n = 0; esc_n = 0; we_n = 0; we_at = 0;
    conflito = 1'b0;
    ee = 0; la = 0; lb = 0; sd = 0; src = 0; op = 0; im = 0;
    mem[0] = v.instr;
    mem[1] = v.byte2;
    zero = v.zero;
    mem_pronto = 1'b1;
    do_reset();
    for (int c = 1; c <= v.lat; c++) begin
      if (c > 1) step();
      le_n += int'(mem_le);
      esc_n += int'(mem_escreve);
      if (habilita_escrita) begin
        we_n++;
        we_at = c;
        ee = end_escrita;
        sd = sel_dado_escrita;
        if (mem_le || mem_escreve) conflito = 1'b1;
      end
      if (c == 3) begin
        op = alu_op; src = alu_src_imm; im = imediato;
        la = end_leitura_A; lb = end_leitura_B;
      end
    end
    step();
    chk($sformatf("v%0d mem_le count", i), le_n, v.n_le);
    chk($sformatf("v%0d mem_escreve count", i), esc_n, v.n_esc);
    chk($sformatf("v%0d we count", i), we_n, (v.we_ciclo != 0) ? 1 : 0);
    chk($sformatf("v%0d we+strobe", i), conflito, 1'b0);
    if (v.we_ciclo != 0) begin
      chk($sformatf("v%0d we cycle", i), we_at, v.we_ciclo);
      chk($sformatf("v%0d end_escrita", i), ee, v.instr[3:2]);
      chk($sformatf("v%0d sel_dado", i), sd, v.sel_dado);
    end
    if (v.chk_exec) begin
      chk($sformatf("v%0d alu_op", i), op, v.alu_op);
      chk($sformatf("v%0d alu_src_imm", i), src, v.src_imm);
      chk($sformatf("v%0d imediato", i), im, v.imed);
      chk($sformatf("v%0d end_leitura_A", i), la, v.instr[3:2]);
      chk($sformatf("v%0d end_leitura_B", i), lb, v.instr[1:0]);
    end
    chk($sformatf("v%0d pc", i), pc, v.pc_fim);
    if (v.halt) begin
      chk($sformatf("v%0d parado", i), parado, 1'b1);
      le_n = 0;
      for (int c = 0; c < 4; c++) begin
        le_n += int'(mem_le || mem_escreve);
        step();
      end
      chk($sformatf("v%0d strobes halted", i), le_n, 0);
    end else begin
      chk($sformatf("v%0d next fetch", i),
          {mem_le, sel_end_mem, parado}, 3'b100);
    end
  endtask

  initial begin
    int cnt, mdr_n, mdr_at, we_at;
    logic sd;
    for (int a = 0; a < 256; a++) mem[a] = 8'hB0;

    tab[0]  = '{8'h06, 8'h00, 1'b0, 4, 8'h01, 1'b0, 1, 0, 4, 1'b0, 1'b1, 3'd0, 1'b0, 8'd2};
    tab[1]  = '{8'h1B, 8'h00, 1'b0, 4, 8'h01, 1'b0, 1, 0, 4, 1'b0, 1'b1, 3'd1, 1'b0, 8'd3};
    tab[2]  = '{8'h2C, 8'h00, 1'b0, 4, 8'h01, 1'b0, 1, 0, 4, 1'b0, 1'b1, 3'd2, 1'b0, 8'd0};
    tab[3]  = '{8'h31, 8'h00, 1'b0, 4, 8'h01, 1'b0, 1, 0, 4, 1'b0, 1'b1, 3'd3, 1'b0, 8'd1};
    tab[4]  = '{8'h47, 8'h00, 1'b0, 4, 8'h01, 1'b0, 1, 0, 4, 1'b0, 1'b1, 3'd4, 1'b0, 8'd3};
    tab[5]  = '{8'h58, 8'h00, 1'b0, 4, 8'h01, 1'b0, 1, 0, 4, 1'b0, 1'b1, 3'd5, 1'b0, 8'd0};
    tab[6]  = '{8'h6E, 8'h00, 1'b0, 4, 8'h01, 1'b0, 1, 0, 4, 1'b0, 1'b1, 3'd0, 1'b1, 8'd2};
    tab[7]  = '{8'h7D, 8'h00, 1'b0, 5, 8'h01, 1'b0, 2, 0, 5, 1'b1, 1'b1, 3'd0, 1'b0, 8'd1};
    tab[8]  = '{8'h84, 8'h00, 1'b0, 4, 8'h01, 1'b0, 1, 1, 0, 1'b0, 1'b1, 3'd0, 1'b0, 8'd0};
    tab[9]  = '{8'h90, 8'h40, 1'b0, 3, 8'h40, 1'b0, 2, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};
    tab[10] = '{8'hA4, 8'h40, 1'b1, 4, 8'h40, 1'b0, 2, 0, 0, 1'b0, 1'b1, 3'd0, 1'b1, 8'd0};
    tab[11] = '{8'hA4, 8'h40, 1'b0, 4, 8'h02, 1'b0, 2, 0, 0, 1'b0, 1'b1, 3'd0, 1'b1, 8'd0};
    tab[12] = '{8'hA7, 8'h80, 1'b1, 4, 8'h80, 1'b0, 2, 0, 0, 1'b0, 1'b1, 3'd0, 1'b1, 8'd0};
    tab[13] = '{8'hB0, 8'h00, 1'b0, 2, 8'h01, 1'b0, 1, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};
    tab[14] = '{8'hF0, 8'h00, 1'b0, 2, 8'h01, 1'b1, 1, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};
    tab[15] = '{8'hC0, 8'h00, 1'b0, 2, 8'h01, 1'b1, 1, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};
    tab[16] = '{8'hE5, 8'h00, 1'b0, 2, 8'h01, 1'b1, 1, 0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0};

    // reset state: every output low while reset is held
    #1;
    chk("reset outputs",
        {pc, sel_end_mem, mem_le, mem_escreve, carrega_mdr,
         end_leitura_A, end_leitura_B, end_escrita,
         habilita_escrita, sel_dado_escrita, alu_op, alu_src_imm,
         imediato, parado, erro_mem}, 0);

    for (int i = 0; i < 17; i++) run_vec(i, tab[i]);

    // LW with three wait cycles in MEMORIA
    mem[0] = 8'h7D;
    mem_pronto = 1'b1;
    do_reset();
    step(); step();
    mem_pronto = 1'b0;
    cnt = 0; mdr_n = 0; mdr_at = 0; we_at = 0; sd = 0;
    for (int c = 4; c <= 9; c++) begin
      step();
      if (c == 7) begin
        mem_pronto = 1'b1;
        #1;
      end
      cnt += int'(mem_le && sel_end_mem);
      if (carrega_mdr) begin mdr_n++; mdr_at = c; end
      if (habilita_escrita) begin we_at = c; sd = sel_dado_escrita; end
    end
    chk("lw wait mem_le cycles", cnt, 4);
    chk("lw wait mdr pulses", mdr_n, 1);
    chk("lw wait mdr cycle", mdr_at, 7);
    chk("lw wait we cycle", we_at, 8);
    chk("lw wait sel_dado", sd, 1'b1);

    // BEQZ placed at 0x10 via a JMP, taken and not taken
    for (int z = 0; z < 2; z++) begin
      mem[0] = 8'h90; mem[1] = 8'h10;
      mem[8'h10] = 8'hA4; mem[8'h11] = 8'h40;
      zero = z[0];
      mem_pronto = 1'b1;
      do_reset();
      cnt = 0;
      for (int c = 1; c <= 7; c++) begin
        if (c > 1) step();
        cnt += int'(habilita_escrita);
      end
      step();
      chk($sformatf("beqz@10 z=%0d pc", z), pc, z ? 8'h40 : 8'h12);
      chk($sformatf("beqz@10 z=%0d we", z), cnt, 0);
    end

    // pc wraps past 0xFF
    mem[0] = 8'h90; mem[1] = 8'hFF; mem[8'hFF] = 8'hB0;
    do_reset();
    for (int c = 2; c <= 6; c++) step();
    chk("pc wrap", {pc, mem_le, sel_end_mem}, {8'h00, 2'b10});

    // HALT then reset brings the core back to fetch at pc 0
    mem[0] = 8'hF0;
    do_reset();
    step(); step(); step();
    chk("halt parado", parado, 1'b1);
    reset = 1'b1;
    #1;
    chk("halt reset held", {pc, parado, mem_le}, 10'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("halt reset release", {pc, parado, mem_le}, {8'h00, 2'b01});

    // async reset in the middle of a SW memory cycle
    mem[0] = 8'h84;
    mem_pronto = 1'b1;
    do_reset();
    step(); step();
    mem_pronto = 1'b0;
    step();
    chk("sw memoria strobe", {mem_escreve, sel_end_mem}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("sw async reset", {mem_escreve, sel_end_mem, mem_le, pc},
        11'd0);
    mem_pronto = 1'b1;
    do_reset();

    // mem_pronto stuck low during BUSCA
    mem_pronto = 1'b0;
    do_reset();
    for (int c = 0; c < 15; c++) step();
    chk("stuck 15 not halted", {parado, erro_mem, mem_le}, 3'b001);
    step();
`ifdef MEM_TIMEOUT_EN
    chk("stuck 16 timeout", {parado, erro_mem, mem_le}, 3'b110);
`else
    chk("stuck 16 waiting",
        {parado, erro_mem, mem_le, sel_end_mem, pc}, {4'b0010, 8'h00});
`endif
    mem_pronto = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
